// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Stores each byte strobed on dat/dat_en in a circular FIFO. Bytes are
// presented first-word-fall-through on a valid/ready port. A sticky overrun
// flag records any byte dropped while the FIFO was full.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   dat       received byte
//   dat_en    one-cycle strobe: dat valid
//   rd_data   head-of-FIFO byte, 8'h00 when empty
//   rd_valid  FIFO non-empty
//   rd_ready  consumer accepts rd_data this cycle
//   count     stored bytes, 0..2**AW
//   full      count == 2**AW
//   overrun   sticky dropped-byte flag
//   ovr_clr   synchronous clear of overrun (a drop in the same cycle wins)
module uart_rx_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    dat,
  input  logic          dat_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overrun,
  input  logic          ovr_clr
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          full_q,   full_d;
  logic          valid_q,  valid_d;
  logic          ovr_q,    ovr_d;

  logic push_c;
  logic pop_c;
  logic drop_c;

  // Pop requires stored data; push into a full FIFO only succeeds alongside a pop.
  assign pop_c  = valid_q & rd_ready;
  assign push_c = dat_en & (~full_q | pop_c);
  assign drop_c = dat_en & full_q & ~pop_c;

  // Next-state for pointers, occupancy and status flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;

    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop_c)       ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;

    // Flags come from the next count so they are registered alongside it.
    full_d  = (count_d == CW'(DEPTH));
    valid_d = (count_d != '0);
  end

  // Control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  // Storage array; contents are don't-care until written, so it is not reset.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= dat;
  end

  assign rd_data  = valid_q ? mem_q[rd_ptr_q] : 8'h00;
  assign rd_valid = valid_q;
  assign count    = count_q;
  assign full     = full_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (AW=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       dat_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       overrun;
  logic       ovr_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_fifo #(.AW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .dat      (dat),
    .dat_en   (dat_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .full     (full),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    dat = b; dat_en = 1'b1;
    step();
    dat_en = 1'b0;
  endtask

  task automatic pop();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    int pushed;
    int popped;

    // Reset state.
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_data", 32'(rd_data), 32'h00);
    step();
    reset = 1'b1;
    step();

    // Single byte latency and pop.
    push(8'hA5);
    check("lat_valid", 32'(rd_valid), 32'd1);
    check("lat_data", 32'(rd_data), 32'hA5);
    check("lat_count", 32'(count), 32'd1);
    pop();
    check("lat_pop_count", 32'(count), 32'd0);
    check("lat_pop_valid", 32'(rd_valid), 32'd0);
    check("lat_empty_data", 32'(rd_data), 32'h00);

    // rd_ready on empty is ignored; push alongside it stores one byte.
    dat = 8'h3C; dat_en = 1'b1; rd_ready = 1'b1;
    step();
    dat_en = 1'b0; rd_ready = 1'b0;
    check("emp_rdy_count", 32'(count), 32'd1);
    check("emp_rdy_data", 32'(rd_data), 32'h3C);
    pop();
    check("emp_rdy_drain", 32'(count), 32'd0);

    // Fill, overrun, ordered drain.
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_ovr0", 32'(overrun), 32'd0);
    push(8'hFF);
    check("drop_ovr", 32'(overrun), 32'd1);
    check("drop_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("drain_data", 32'(rd_data), 32'(i));
      pop();
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(rd_valid), 32'd0);
    check("drain_full", 32'(full), 32'd0);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("clr_ovr", 32'(overrun), 32'd0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    dat = 8'h55; dat_en = 1'b1; rd_ready = 1'b1;
    step();
    dat_en = 1'b0; rd_ready = 1'b0;
    check("sim_count", 32'(count), 32'd16);
    check("sim_ovr", 32'(overrun), 32'd0);
    check("sim_full", 32'(full), 32'd1);
    for (int i = 1; i < 16; i++) begin
      check("sim_data", 32'(rd_data), 32'(8'h10 + i));
      pop();
    end
    check("sim_last", 32'(rd_data), 32'h55);
    pop();
    check("sim_empty", 32'(count), 32'd0);

    // Drop and clear in the same cycle: set wins.
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    dat = 8'hEE; dat_en = 1'b1; ovr_clr = 1'b1;
    step();
    dat_en = 1'b0;
    check("race_ovr", 32'(overrun), 32'd1);
    step();
    ovr_clr = 1'b0;
    check("race_clr", 32'(overrun), 32'd0);

    // Drain to five entries, then async reset mid-cycle.
    for (int i = 0; i < 11; i++) pop();
    check("pre_rst_count", 32'(count), 32'd5);
    check("pre_rst_data", 32'(rd_data), 32'h2B);
    push(8'hEE);
    for (int i = 0; i < 11; i++) push(8'hEE);
    push(8'hEE);
    check("pre_rst_ovr", 32'(overrun), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(rd_valid), 32'd0);
    check("arst_ovr", 32'(overrun), 32'd0);
    check("arst_full", 32'(full), 32'd0);
    dat = 8'h99; dat_en = 1'b1;
    step();
    check("arst_hold", 32'(count), 32'd0);
    #2;
    reset = 1'b1;
    step();
    dat_en = 1'b0;
    check("rel_count", 32'(count), 32'd1);
    check("rel_data", 32'(rd_data), 32'h99);
    pop();

    // Interleaved traffic across pointer wrap, occupancy held to 0..3.
    pushed = 0;
    popped = 0;
    while (popped < 40) begin
      if (pushed < 40 && q.size() < 3 && (q.size() == 0 || ($urandom % 2) == 0)) begin
        b = 8'((pushed * 37 + 11) & 8'hFF);
        q.push_back(b);
        push(b);
        pushed++;
      end else begin
        b = q.pop_front();
        check("wrap_data", 32'(rd_data), 32'(b));
        pop();
        popped++;
      end
      check("wrap_count", 32'(count), 32'(q.size()));
      check("wrap_max", 32'(count <= 5'd3), 32'd1);
      repeat ($urandom_range(0, 2)) step();
    end
    check("wrap_end_valid", 32'(rd_valid), 32'd0);
    check("wrap_end_ovr", 32'(overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
